// File: rtl/cr_tlvp_frm_arb.sv
// rtl/cr_tlvp_frm_arb.sv - frame-atomic round-robin arbiter in front of the TLV parser inbound stream
//
// Shares one inbound AXI4-stream port among N_REQ requesters. A grant is taken
// in ARB, then held in XFER from the first beat through the tlast handshake, so
// frames never interleave at the parser input.
//
// Parameters:
//   N_REQ        number of requesters (2..8)
//   WDOG_CYCLES  stall limit in cycles (watchdog build only)
//
// Ports:
//   clk            core clock
//   rst            synchronous, active-high reset
//   axi4s_req_in   per-requester stream inputs (data/keep/last/valid)
//   axi4s_req_out  per-requester tready
//   axi4s_ob_out   arbitrated stream towards the parser inbound port
//   axi4s_ob_in    parser inbound tready
//   req_mask       1 = requester excluded from new grants
//   arb_gnt        one-hot current grant, 0 when idle
//   arb_busy       1 while a frame is locked
//   arb_wdog_err   sticky stall error (constant 0 without the watchdog)
//
// Build option: CR_TLVP_ARB_WDOG_EN compiles in the stall watchdog.

package cr_tlvp_frm_arb_pkg;

    typedef struct packed {
        logic [63:0] tdata;
        logic [7:0]  tkeep;
        logic        tlast;
        logic        tvalid;
    } axi4s_dp_bus_t;

    typedef struct packed {
        logic tready;
    } axi4s_dp_rdy_t;

endpackage

module cr_tlvp_frm_arb
    import cr_tlvp_frm_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  axi4s_dp_bus_t     axi4s_req_in  [N_REQ],
    output axi4s_dp_rdy_t     axi4s_req_out [N_REQ],
    output axi4s_dp_bus_t     axi4s_ob_out,
    input  axi4s_dp_rdy_t     axi4s_ob_in,
    input  logic [N_REQ-1:0]  req_mask,
    output logic [N_REQ-1:0]  arb_gnt,
    output logic              arb_busy,
    output logic              arb_wdog_err
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        ARB  = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] gnt_nxt;
    logic [IW-1:0]    gnt_idx;
    logic [IW-1:0]    gnt_idx_nxt;
    logic [IW-1:0]    last_gnt;
    logic [IW-1:0]    last_gnt_nxt;
    logic [N_REQ-1:0] elig;
    logic             any_elig;
    logic [IW-1:0]    win_idx;
    logic             beat_xfer;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = axi4s_req_in[i].tvalid & ~req_mask[i];
        end
    end

    assign any_elig = |elig;

    // Rotating-priority search starting just above the previous winner.
    // cand is one bit wider than an index so last_gnt + N_REQ never overflows
    // before the wrap subtraction.
    always_comb begin
        logic [IW:0] cand;
        logic        found;
        win_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, last_gnt} + (IW+1)'(k);
            if (cand >= (IW+1)'(N_REQ)) begin
                cand = cand - (IW+1)'(N_REQ);
            end
            if (!found && elig[cand[IW-1:0]]) begin
                win_idx = cand[IW-1:0];
                found   = 1'b1;
            end
        end
    end

    // Datapath: pure combinational mux on the registered grant. In ARB the
    // output is held idle and nobody is acknowledged.
    always_comb begin
        axi4s_ob_out = '0;
        if (state == XFER) begin
            axi4s_ob_out = axi4s_req_in[gnt_idx];
        end
    end

    // gnt is all-zero outside XFER, so it alone qualifies the ready fan-out.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            axi4s_req_out[i].tready = gnt[i] & axi4s_ob_in.tready;
        end
    end

    assign beat_xfer = (state == XFER) & axi4s_ob_out.tvalid & axi4s_ob_in.tready;

    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        gnt_idx_nxt  = gnt_idx;
        last_gnt_nxt = last_gnt;
        case (state)
            ARB: begin
                if (any_elig) begin
                    state_nxt   = XFER;
                    gnt_idx_nxt = win_idx;
                    gnt_nxt     = N_REQ'(1) << win_idx;
                end
            end
            XFER: begin
                // Only the tlast handshake releases the lock; valid gaps and
                // mask changes mid-frame are deliberately ignored here.
                if (beat_xfer && axi4s_ob_out.tlast) begin
                    state_nxt    = ARB;
                    gnt_nxt      = '0;
                    last_gnt_nxt = gnt_idx;
                end
            end
            default: begin
                state_nxt = ARB;
                gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB;
            gnt      <= '0;
            gnt_idx  <= '0;
            last_gnt <= IW'(N_REQ - 1);
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            gnt_idx  <= gnt_idx_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

    assign arb_gnt  = gnt;
    assign arb_busy = (state == XFER);

`ifdef CR_TLVP_ARB_WDOG_EN
    localparam int              WW        = $clog2(WDOG_CYCLES + 1);
    localparam logic [WW-1:0]   WDOG_MAX  = WW'(WDOG_CYCLES);
    localparam logic [WW-1:0]   WDOG_LAST = WW'(WDOG_CYCLES - 1);

    logic [WW-1:0] wdog_cnt;
    logic          wdog_err;

    // Counts consecutive stalled XFER cycles. The error flag is raised on the
    // stall that brings the count to WDOG_CYCLES, so it is visible in the
    // following cycle. The grant is never released by the watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt <= '0;
            wdog_err <= 1'b0;
        end else if (state != XFER || beat_xfer) begin
            wdog_cnt <= '0;
        end else begin
            if (wdog_cnt != WDOG_MAX) begin
                wdog_cnt <= wdog_cnt + WW'(1);
            end
            if (wdog_cnt == WDOG_LAST) begin
                wdog_err <= 1'b1;
            end
        end
    end

    assign arb_wdog_err = wdog_err;
`else
    assign arb_wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_cr_tlvp_frm_arb.sv
// tb/tb_cr_tlvp_frm_arb.sv - self-checking bench for cr_tlvp_frm_arb
module tb_cr_tlvp_frm_arb;
    import cr_tlvp_frm_arb_pkg::*;

    localparam int N    = 4;
    localparam int WDOG = 16;
`ifdef CR_TLVP_ARB_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    axi4s_dp_bus_t req_in  [N];
    axi4s_dp_rdy_t req_out [N];
    axi4s_dp_bus_t ob_out;
    axi4s_dp_rdy_t ob_in;
    logic [N-1:0]  req_mask;
    logic [N-1:0]  arb_gnt;
    logic          arb_busy;
    logic          arb_wdog_err;

    int checks = 0;
    int errors = 0;

    // Upstream frame sources
    int src_len  [N];
    int src_pos  [N];
    int src_fid  [N];
    int src_salt [N];
    bit src_act  [N];
    bit src_gap  [N];
    bit hs       [N];
    bit rnd_mode = 1'b0;
    int auto_len = 0;

    always #5 clk = ~clk;

    cr_tlvp_frm_arb #(
        .N_REQ       (N),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .axi4s_req_in  (req_in),
        .axi4s_req_out (req_out),
        .axi4s_ob_out  (ob_out),
        .axi4s_ob_in   (ob_in),
        .req_mask      (req_mask),
        .arb_gnt       (arb_gnt),
        .arb_busy      (arb_busy),
        .arb_wdog_err  (arb_wdog_err)
    );

    function automatic logic [63:0] beat_data(int i, int fid, int pos, int len, int salt);
        return {4'(i), 12'(fid), 8'(pos), 8'(len), 32'(salt) ^ 32'(pos)};
    endfunction

    function automatic logic [N-1:0] rdy_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = req_out[i].tready;
        return v;
    endfunction

    task automatic drive_sources();
        for (int i = 0; i < N; i++) begin
            req_in[i].tvalid = src_act[i] && !src_gap[i];
            req_in[i].tlast  = src_act[i] && (src_pos[i] == src_len[i] - 1);
            req_in[i].tkeep  = 8'hFF;
            req_in[i].tdata  = beat_data(i, src_fid[i], src_pos[i], src_len[i], src_salt[i]);
        end
    endtask

    task automatic start_frame(int i, int len);
        src_act[i]  = 1'b1;
        src_len[i]  = len;
        src_pos[i]  = 0;
        src_fid[i]  = src_fid[i] + 1;
        src_salt[i] = int'($urandom);
    endtask

    task automatic reset_sources();
        for (int i = 0; i < N; i++) begin
            src_act[i] = 1'b0;
            src_gap[i] = 1'b0;
            hs[i]      = 1'b0;
        end
        drive_sources();
    endtask

    // Sample away from the active edge and note which sources handshook.
    task automatic sample();
        @(negedge clk);
        for (int i = 0; i < N; i++) hs[i] = req_in[i].tvalid && req_out[i].tready;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                src_pos[i] = src_pos[i] + 1;
                if (src_pos[i] == src_len[i]) src_act[i] = 1'b0;
            end
            hs[i] = 1'b0;
            if (auto_len > 0 && !src_act[i]) start_frame(i, auto_len);
            if (rnd_mode) begin
                if (!src_act[i] && $urandom_range(0, 3) == 0) start_frame(i, int'($urandom_range(1, 6)));
                src_gap[i] = ($urandom_range(0, 4) == 0);
            end
        end
        drive_sources();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        reset_sources();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        bit done;
        bit any;
        n = 0;
        done = 1'b0;
        rnd_mode = 1'b0;
        auto_len = 0;
        req_mask = '0;
        ob_in.tready = 1'b1;
        for (int i = 0; i < N; i++) src_gap[i] = 1'b0;
        drive_sources();
        while (!done && n < 200) begin
            sample();
            any = 1'b0;
            for (int i = 0; i < N; i++) any = any | src_act[i];
            done = !arb_busy && !any;
            next_cycle();
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: busy=%0b after %0d cycles, required idle", arb_busy, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_mask = '0;
        ob_in.tready = 1'b1;
        reset_sources();
        repeat (2) next_cycle();
        sample();
        checks += 5;
        if (arb_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b required 0", arb_busy); end
        if (arb_gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b required 0000", arb_gnt); end
        if (ob_out.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %0b required 0", ob_out.tvalid); end
        if (rdy_vec() !== 4'b0000) begin errors++; $display("FAIL reset_tready: got %b required 0000", rdy_vec()); end
        if (arb_wdog_err !== 1'b0) begin errors++; $display("FAIL reset_wdog: got %0b required 0", arb_wdog_err); end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int fid;
        int salt;
        ob_in.tready = 1'b1;
        start_frame(2, 3);
        fid  = src_fid[2];
        salt = src_salt[2];
        drive_sources();
        sample();
        checks++;
        if (arb_busy !== 1'b0) begin errors++; $display("FAIL basic_c0_busy: got %0b required 0", arb_busy); end
        next_cycle();
        for (int b = 0; b < 3; b++) begin
            sample();
            checks += 5;
            if (arb_gnt !== 4'b0100) begin errors++; $display("FAIL basic_gnt beat %0d: got %b required 0100", b, arb_gnt); end
            if (ob_out.tvalid !== 1'b1) begin errors++; $display("FAIL basic_tvalid beat %0d: got %0b required 1", b, ob_out.tvalid); end
            if (ob_out.tdata !== beat_data(2, fid, b, 3, salt)) begin
                errors++; $display("FAIL basic_data beat %0d: got %h required %h", b, ob_out.tdata, beat_data(2, fid, b, 3, salt));
            end
            if (ob_out.tlast !== (b == 2)) begin errors++; $display("FAIL basic_tlast beat %0d: got %0b", b, ob_out.tlast); end
            if (rdy_vec() !== 4'b0100) begin errors++; $display("FAIL basic_tready beat %0d: got %b required 0100", b, rdy_vec()); end
            next_cycle();
        end
        sample();
        checks += 2;
        if (arb_busy !== 1'b0) begin errors++; $display("FAIL basic_c4_busy: got %0b required 0", arb_busy); end
        if (arb_gnt !== 4'b0000) begin errors++; $display("FAIL basic_c4_gnt: got %b required 0000", arb_gnt); end
        next_cycle();
    endtask

    task automatic test_round_robin();
        int k;
        int prev;
        bit in_frame;
        int s;
        k = 0;
        prev = -1;
        in_frame = 1'b0;
        apply_reset();
        ob_in.tready = 1'b1;
        auto_len = 2;
        for (int i = 0; i < N; i++) start_frame(i, 2);
        drive_sources();
        for (int c = 0; c < 15; c++) begin
            sample();
            if (ob_out.tvalid && ob_in.tready) begin
                s = int'(ob_out.tdata[63:60]);
                checks++;
                if (arb_gnt !== N'(1 << s)) begin errors++; $display("FAIL rr_gnt cycle %0d: got %b for source %0d", c, arb_gnt, s); end
                if (in_frame) begin
                    checks++;
                    if (s != prev) begin errors++; $display("FAIL rr_interleave cycle %0d: got source %0d required %0d", c, s, prev); end
                end
                prev = s;
                in_frame = !ob_out.tlast;
                if (ob_out.tlast) begin
                    checks += 2;
                    if (s != k % N) begin errors++; $display("FAIL rr_order frame %0d: got %0d required %0d", k, s, k % N); end
                    if (c != 2 + 3 * k) begin errors++; $display("FAIL rr_period frame %0d: ended cycle %0d required %0d", k, c, 2 + 3 * k); end
                    k++;
                end
            end
            next_cycle();
        end
        checks++;
        if (k != 5) begin errors++; $display("FAIL rr_count: got %0d frames required 5", k); end
        drain();
    endtask

    task automatic test_backpressure();
        int n_hs;
        n_hs = 0;
        start_frame(1, 4);
        ob_in.tready = 1'b0;
        drive_sources();
        for (int c = 0; c <= 7; c++) begin
            ob_in.tready = (c % 2 == 1);
            sample();
            if (c >= 1) begin
                checks += 2;
                if (arb_busy !== 1'b1) begin errors++; $display("FAIL bp_lock cycle %0d: busy got %0b required 1", c, arb_busy); end
                if (rdy_vec() !== (ob_in.tready ? 4'b0010 : 4'b0000)) begin
                    errors++; $display("FAIL bp_tready cycle %0d: got %b", c, rdy_vec());
                end
            end
            if (ob_out.tvalid && ob_in.tready) n_hs++;
            next_cycle();
        end
        sample();
        checks += 2;
        if (n_hs != 4) begin errors++; $display("FAIL bp_handshakes: got %0d required 4", n_hs); end
        if (arb_busy !== 1'b0) begin errors++; $display("FAIL bp_release: busy got %0b required 0", arb_busy); end
        next_cycle();
        drain();
    endtask

    task automatic test_mask();
        int n1;
        n1 = 0;
        ob_in.tready = 1'b1;
        req_mask = 4'b0001;
        start_frame(0, 2);
        start_frame(1, 3);
        drive_sources();
        for (int c = 0; c <= 6; c++) begin
            if (c == 2) req_mask = 4'b0011;
            if (c == 5) req_mask = 4'b0000;
            sample();
            if (hs[1]) n1++;
            if (c >= 1 && c <= 3) begin
                checks++;
                if (arb_gnt !== 4'b0010) begin errors++; $display("FAIL mask_gnt cycle %0d: got %b required 0010", c, arb_gnt); end
            end
            if (c == 5) begin
                checks++;
                if (arb_busy !== 1'b0) begin errors++; $display("FAIL mask_block: busy got %0b required 0", arb_busy); end
            end
            if (c == 6) begin
                checks++;
                if (arb_gnt !== 4'b0001) begin errors++; $display("FAIL mask_release: got %b required 0001", arb_gnt); end
            end
            next_cycle();
        end
        checks++;
        if (n1 != 3) begin errors++; $display("FAIL mask_frame: got %0d beats from req1 required 3", n1); end
        drain();
    endtask

    task automatic test_reset_mid_frame();
        ob_in.tready = 1'b1;
        start_frame(3, 5);
        drive_sources();
        sample();
        next_cycle();
        sample();
        next_cycle();
        rst = 1'b1;
        sample();
        next_cycle();
        rst = 1'b0;
        reset_sources();
        start_frame(0, 2);
        start_frame(3, 2);
        drive_sources();
        sample();
        checks += 5;
        if (arb_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %0b required 0", arb_busy); end
        if (arb_gnt !== 4'b0000) begin errors++; $display("FAIL rstmid_gnt: got %b required 0000", arb_gnt); end
        if (ob_out.tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid: got %0b required 0", ob_out.tvalid); end
        if (rdy_vec() !== 4'b0000) begin errors++; $display("FAIL rstmid_tready: got %b required 0000", rdy_vec()); end
        if (arb_wdog_err !== 1'b0) begin errors++; $display("FAIL rstmid_wdog: got %0b required 0", arb_wdog_err); end
        next_cycle();
        sample();
        checks++;
        if (arb_gnt !== 4'b0001) begin errors++; $display("FAIL rstmid_first: got %b required 0001", arb_gnt); end
        next_cycle();
        drain();
    endtask

    task automatic test_watchdog();
        apply_reset();
        ob_in.tready = 1'b1;
        req_mask = '0;
        start_frame(0, 2);
        drive_sources();
        sample();
        next_cycle();
        src_gap[0] = 1'b1;
        drive_sources();
        for (int c = 1; c <= 17; c++) begin
            sample();
            if (c == 16) begin
                checks++;
                if (arb_wdog_err !== 1'b0) begin errors++; $display("FAIL wdog_early: got %0b required 0", arb_wdog_err); end
            end
            if (c == 17) begin
                checks += 2;
                if (arb_wdog_err !== WDOG_ON) begin errors++; $display("FAIL wdog_set: got %0b required %0b", arb_wdog_err, WDOG_ON); end
                if (arb_gnt !== 4'b0001) begin errors++; $display("FAIL wdog_hold: got %b required 0001", arb_gnt); end
            end
            next_cycle();
        end
        src_gap[0] = 1'b0;
        drive_sources();
        repeat (3) begin
            sample();
            next_cycle();
        end
        sample();
        checks += 2;
        if (arb_busy !== 1'b0) begin errors++; $display("FAIL wdog_done: busy got %0b required 0", arb_busy); end
        if (arb_wdog_err !== WDOG_ON) begin errors++; $display("FAIL wdog_sticky: got %0b required %0b", arb_wdog_err, WDOG_ON); end
        next_cycle();
        rst = 1'b1;
        sample();
        checks++;
        if (arb_wdog_err !== WDOG_ON) begin errors++; $display("FAIL wdog_pre_rst: got %0b required %0b", arb_wdog_err, WDOG_ON); end
        next_cycle();
        rst = 1'b0;
        sample();
        checks++;
        if (arb_wdog_err !== 1'b0) begin errors++; $display("FAIL wdog_clear: got %0b required 0", arb_wdog_err); end
        next_cycle();
    endtask

    // Reference: idle/locked owner, last winner, stall run length.
    task automatic test_random();
        int m_src;
        int m_last;
        int m_stall;
        bit m_err;
        int win;
        int j;
        logic [N-1:0] eg;
        logic [N-1:0] er;
        apply_reset();
        m_src = -1;
        m_last = N - 1;
        m_stall = 0;
        m_err = 1'b0;
        rnd_mode = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            ob_in.tready = ($urandom_range(0, 3) != 0);
            req_mask = N'($urandom) & N'($urandom);
            sample();
            checks++;
            if (arb_wdog_err !== m_err) begin errors++; $display("FAIL rnd_wdog cycle %0d: got %0b required %0b", cyc, arb_wdog_err, m_err); end
            if (m_src < 0) begin
                checks += 4;
                if (arb_busy !== 1'b0) begin errors++; $display("FAIL rnd_idle_busy cycle %0d: got %0b required 0", cyc, arb_busy); end
                if (arb_gnt !== '0) begin errors++; $display("FAIL rnd_idle_gnt cycle %0d: got %b required 0", cyc, arb_gnt); end
                if (ob_out.tvalid !== 1'b0) begin errors++; $display("FAIL rnd_idle_tvalid cycle %0d: got %0b required 0", cyc, ob_out.tvalid); end
                if (rdy_vec() !== '0) begin errors++; $display("FAIL rnd_idle_tready cycle %0d: got %b required 0", cyc, rdy_vec()); end
                win = -1;
                for (int k = 1; k <= N; k++) begin
                    j = (m_last + k) % N;
                    if (win < 0 && req_in[j].tvalid && !req_mask[j]) win = j;
                end
                m_stall = 0;
                m_src = win;
            end else begin
                eg = '0;
                eg[m_src] = 1'b1;
                er = ob_in.tready ? eg : '0;
                checks += 4;
                if (arb_busy !== 1'b1) begin errors++; $display("FAIL rnd_busy cycle %0d: got %0b required 1", cyc, arb_busy); end
                if (arb_gnt !== eg) begin errors++; $display("FAIL rnd_gnt cycle %0d: got %b required %b", cyc, arb_gnt, eg); end
                if (ob_out.tvalid !== req_in[m_src].tvalid) begin
                    errors++; $display("FAIL rnd_tvalid cycle %0d: got %0b required %0b", cyc, ob_out.tvalid, req_in[m_src].tvalid);
                end
                if (rdy_vec() !== er) begin errors++; $display("FAIL rnd_tready cycle %0d: got %b required %b", cyc, rdy_vec(), er); end
                if (req_in[m_src].tvalid) begin
                    checks++;
                    if (ob_out !== req_in[m_src]) begin errors++; $display("FAIL rnd_beat cycle %0d: got %h required %h", cyc, ob_out, req_in[m_src]); end
                end
                if (req_in[m_src].tvalid && ob_in.tready) begin
                    m_stall = 0;
                    if (req_in[m_src].tlast) begin
                        m_last = m_src;
                        m_src = -1;
                    end
                end else begin
                    m_stall++;
                    if (WDOG_ON && m_stall >= WDOG) m_err = 1'b1;
                end
            end
            next_cycle();
        end
        drain();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            src_fid[i]  = 0;
            src_len[i]  = 1;
            src_pos[i]  = 0;
            src_salt[i] = 0;
        end
        rst = 1'b1;
        ob_in.tready = 1'b0;
        req_mask = '0;
        reset_sources();
        test_reset();
        test_basic();
        test_round_robin();
        test_backpressure();
        test_mask();
        test_reset_mid_frame();
        test_watchdog();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
